// File: rtl/snake_move_ctrl.sv
// Snake movement and collision engine: key-driven heading, periodic stepping,
// segment shift register, sticky wall/body collision flags, renderer lookup.
module snake_move_ctrl #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 16,
  parameter int MOVE_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key1_press,
  input  logic       key2_press,
  input  logic       key3_press,
  input  logic       key4_press,
  input  logic [1:0] game_status,
  input  logic       restart,
  input  logic       grow,
  input  logic [5:0] query_x,
  input  logic [4:0] query_y,
  output logic       query_body,
  output logic       query_head,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] snake_len,
  output logic       move_tick,
  output logic       hit_wall,
  output logic       hit_body
);

  localparam logic [1:0] ST_RESTART = 2'b00;
  localparam logic [1:0] ST_START   = 2'b01;
  localparam logic [1:0] ST_PLAY    = 2'b10;
  localparam logic [1:0] ST_DIE     = 2'b11;

  // Encoding chosen so that the opposite heading is dir ^ 2'b01.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int                CNT_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MOVE_DIV - 1);
  localparam int                IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [4:0]        LEN_MAX  = 5'(MAX_LEN);

  logic [5:0]       r_seg_x [MAX_LEN];
  logic [4:0]       r_seg_y [MAX_LEN];
  logic [4:0]       r_len;
  logic [1:0]       r_dir;
  logic [1:0]       r_last_dir;
  logic             r_grow_pend;
  logic [CNT_W-1:0] r_cnt;
  logic             r_move_tick;
  logic             r_hit_wall;
  logic             r_hit_body;

  logic       w_cnt_en;
  logic       w_step;
  logic [6:0] w_next_x;
  logic [5:0] w_next_y;
  logic       w_out_of_bounds;
  logic       w_grow_eff;
  logic       w_self_hit;
  logic       w_step_ok;
  logic       w_step_wall;
  logic       w_step_body;
  logic       w_key_valid;
  logic [1:0] w_key_dir;
  logic [1:0] w_ref_dir;
  logic       w_key_accept;
  logic       w_status_steer;

  assign w_cnt_en = (game_status == ST_PLAY) && !r_hit_wall && !r_hit_body;
  assign w_step   = w_cnt_en && (r_cnt == CNT_LAST);

  // One bit wider than the coordinates so that 0-1 wraps to a large value.
  always_comb begin
    w_next_x = {1'b0, r_seg_x[0]};
    w_next_y = {1'b0, r_seg_y[0]};
    case (r_dir)
      DIR_UP:    w_next_y = {1'b0, r_seg_y[0]} - 6'd1;
      DIR_DOWN:  w_next_y = {1'b0, r_seg_y[0]} + 6'd1;
      DIR_LEFT:  w_next_x = {1'b0, r_seg_x[0]} - 7'd1;
      default:   w_next_x = {1'b0, r_seg_x[0]} + 7'd1;
    endcase
  end

  assign w_out_of_bounds = (w_next_x >= 7'(GRID_W)) || (w_next_y >= 6'(GRID_H));
  assign w_grow_eff      = r_grow_pend || grow;

  // The tail cell only blocks when the snake is about to grow, since it vacates otherwise.
  always_comb begin
    w_self_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (({1'b0, r_seg_x[IDX_W'(i)]} == w_next_x) && ({1'b0, r_seg_y[IDX_W'(i)]} == w_next_y)) begin
        if ((5'(i + 1) < r_len) || ((5'(i + 1) == r_len) && w_grow_eff)) begin
          w_self_hit = 1'b1;
        end
      end
    end
  end

  assign w_step_ok   = w_step && !w_out_of_bounds && !w_self_hit;
  assign w_step_wall = w_step && w_out_of_bounds;
  assign w_step_body = w_step && !w_out_of_bounds && w_self_hit;

  always_comb begin
    w_key_valid = 1'b1;
    w_key_dir   = r_dir;
    if (key1_press) begin
      w_key_dir = DIR_UP;
    end else if (key2_press) begin
      w_key_dir = DIR_DOWN;
    end else if (key3_press) begin
      w_key_dir = DIR_LEFT;
    end else if (key4_press) begin
      w_key_dir = DIR_RIGHT;
    end else begin
      w_key_valid = 1'b0;
    end
  end

  // A step executing this cycle already counts as the last executed move.
  assign w_ref_dir      = w_step_ok ? r_dir : r_last_dir;
  assign w_status_steer = (game_status == ST_START) || (game_status == ST_PLAY);
  assign w_key_accept   = w_key_valid && w_status_steer && (w_key_dir != (w_ref_dir ^ 2'b01));

  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        r_seg_x[IDX_W'(i)] <= '0;
        r_seg_y[IDX_W'(i)] <= '0;
      end
      r_seg_x[0]  <= 6'd20;
      r_seg_y[0]  <= 5'd15;
      r_seg_x[1]  <= 6'd19;
      r_seg_y[1]  <= 5'd15;
      r_seg_x[2]  <= 6'd18;
      r_seg_y[2]  <= 5'd15;
      r_len       <= 5'd3;
      r_dir       <= DIR_RIGHT;
      r_last_dir  <= DIR_RIGHT;
      r_grow_pend <= 1'b0;
      r_cnt       <= '0;
      r_move_tick <= 1'b0;
      r_hit_wall  <= 1'b0;
      r_hit_body  <= 1'b0;
    end else begin
      r_move_tick <= w_step_ok;

      if (!w_cnt_en || (r_cnt == CNT_LAST)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_key_accept) begin
        r_dir <= w_key_dir;
      end

      if (w_step_wall) begin
        r_hit_wall <= 1'b1;
      end
      if (w_step_body) begin
        r_hit_body <= 1'b1;
      end

      if (grow) begin
        r_grow_pend <= 1'b1;
      end

      if (w_step_ok) begin
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
          r_seg_x[IDX_W'(i)] <= r_seg_x[IDX_W'(i - 1)];
          r_seg_y[IDX_W'(i)] <= r_seg_y[IDX_W'(i - 1)];
        end
        r_seg_x[0] <= w_next_x[5:0];
        r_seg_y[0] <= w_next_y[4:0];
        if (w_grow_eff && (r_len < LEN_MAX)) begin
          r_len <= r_len + 5'd1;
        end
        r_grow_pend <= 1'b0;
        r_last_dir  <= r_dir;
      end
    end
  end

  always_comb begin
    query_body = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < r_len) && (r_seg_x[IDX_W'(i)] == query_x) && (r_seg_y[IDX_W'(i)] == query_y)) begin
        query_body = 1'b1;
      end
    end
  end

  assign query_head = (r_seg_x[0] == query_x) && (r_seg_y[0] == query_y);
  assign head_x     = r_seg_x[0];
  assign head_y     = r_seg_y[0];
  assign snake_len  = r_len;
  assign move_tick  = r_move_tick;
  assign hit_wall   = r_hit_wall;
  assign hit_body   = r_hit_body;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scoreboard bench for snake_move_ctrl: a list-based snake model predicts each
// step outcome; a negedge monitor pops predictions whenever the DUT reports one.
module tb_snake_move_ctrl;

  localparam int GW  = 40;
  localparam int GH  = 30;
  localparam int ML  = 16;
  localparam int DIV = 4;

  localparam int ST_RESTART = 0;
  localparam int ST_START   = 1;
  localparam int ST_PLAY    = 2;
  localparam int ST_DIE     = 3;

  localparam int D_UP    = 0;
  localparam int D_DOWN  = 1;
  localparam int D_LEFT  = 2;
  localparam int D_RIGHT = 3;

  localparam int K_MOVE = 1;
  localparam int K_WALL = 2;
  localparam int K_BODY = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key1_press = 1'b0;
  logic       key2_press = 1'b0;
  logic       key3_press = 1'b0;
  logic       key4_press = 1'b0;
  logic [1:0] game_status = 2'd1;
  logic       restart = 1'b0;
  logic       grow = 1'b0;
  logic [5:0] query_x = '0;
  logic [4:0] query_y = '0;
  logic       query_body;
  logic       query_head;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [4:0] snake_len;
  logic       move_tick;
  logic       hit_wall;
  logic       hit_body;

  snake_move_ctrl #(
    .GRID_W  (GW),
    .GRID_H  (GH),
    .MAX_LEN (ML),
    .MOVE_DIV(DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key1_press (key1_press),
    .key2_press (key2_press),
    .key3_press (key3_press),
    .key4_press (key4_press),
    .game_status(game_status),
    .restart    (restart),
    .grow       (grow),
    .query_x    (query_x),
    .query_y    (query_y),
    .query_body (query_body),
    .query_head (query_head),
    .head_x     (head_x),
    .head_y     (head_y),
    .snake_len  (snake_len),
    .move_tick  (move_tick),
    .hit_wall   (hit_wall),
    .hit_body   (hit_body)
  );

  always #5 clk = ~clk;

  int unsigned ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    int          kind;
    int unsigned cyc;
    int          hx;
    int          hy;
    int          len;
  } exp_t;

  exp_t exp_q[$];

  // Reference snake: ordered cell list, head first.
  int sx[$];
  int sy[$];
  int mdir, mlast, mcnt;
  bit mpend, mw, mb;

  function automatic void model_init();
    sx = '{20, 19, 18};
    sy = '{15, 15, 15};
    mdir = D_RIGHT;
    mlast = D_RIGHT;
    mcnt = 0;
    mpend = 0;
    mw = 0;
    mb = 0;
  endfunction

  function automatic int opposite(int d);
    case (d)
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      D_LEFT:  return D_RIGHT;
      default: return D_LEFT;
    endcase
  endfunction

  function automatic void push_exp(int kind);
    exp_t e;
    e.kind = kind;
    e.cyc  = ncyc + 1;
    e.hx   = sx[0];
    e.hy   = sy[0];
    e.len  = sx.size();
    exp_q.push_back(e);
  endfunction

  // Predicts the effect of the coming clock edge given this cycle's inputs.
  function automatic void model_step(logic [3:0] keys, int st, bit rs, bit gr);
    int nx, ny, kd;
    bit step, hit, grow_eff;
    if (rs) begin
      model_init();
      return;
    end
    step = (st == ST_PLAY) && !mw && !mb && (mcnt == DIV - 1);
    if ((st == ST_PLAY) && !mw && !mb) mcnt = (mcnt + 1) % DIV;
    else mcnt = 0;
    grow_eff = mpend || gr;
    if (gr) mpend = 1;
    if (step) begin
      nx = sx[0];
      ny = sy[0];
      case (mdir)
        D_UP:    ny = ny - 1;
        D_DOWN:  ny = ny + 1;
        D_LEFT:  nx = nx - 1;
        default: nx = nx + 1;
      endcase
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
        mw = 1;
        push_exp(K_WALL);
      end else begin
        hit = 0;
        for (int i = 0; i < sx.size(); i++)
          if (sx[i] == nx && sy[i] == ny && (i < sx.size() - 1 || grow_eff)) hit = 1;
        if (hit) begin
          mb = 1;
          push_exp(K_BODY);
        end else begin
          sx.push_front(nx);
          sy.push_front(ny);
          if (!(grow_eff && sx.size() <= ML)) begin
            void'(sx.pop_back());
            void'(sy.pop_back());
          end
          mpend = 0;
          mlast = mdir;
          push_exp(K_MOVE);
        end
      end
    end
    if ((st == ST_START || st == ST_PLAY) && keys != 4'b0) begin
      kd = keys[3] ? D_UP : keys[2] ? D_DOWN : keys[1] ? D_LEFT : D_RIGHT;
      if (kd != opposite(mlast)) mdir = kd;
    end
  endfunction

  // keys = {key1, key2, key3, key4}
  task automatic cyc(logic [3:0] keys, int st, bit rs, bit gr);
    @(posedge clk);
    #1;
    {key1_press, key2_press, key3_press, key4_press} = keys;
    game_status = 2'(st);
    restart = rs;
    grow = gr;
    model_step(keys, st, rs, gr);
  endtask

  task automatic idle(int st, int n);
    repeat (n) cyc(4'b0, st, 1'b0, 1'b0);
  endtask

  task automatic period(logic [3:0] keys, bit gr);
    cyc(keys, ST_PLAY, 1'b0, gr);
    idle(ST_PLAY, DIV - 1);
  endtask

  // Only valid right after an idle non-PLAY cycle, when the DUT and model agree.
  task automatic check_state(string tag);
    chk({tag, "_head_x"}, int'(head_x), sx[0]);
    chk({tag, "_head_y"}, int'(head_y), sy[0]);
    chk({tag, "_len"}, int'(snake_len), sx.size());
    chk({tag, "_hit_wall"}, int'(hit_wall), int'(mw));
    chk({tag, "_hit_body"}, int'(hit_body), int'(mb));
  endtask

  task automatic qchk(int x, int y);
    bit eb, eh;
    eb = 0;
    for (int i = 0; i < sx.size(); i++) if (sx[i] == x && sy[i] == y) eb = 1;
    eh = (sx[0] == x) && (sy[0] == y);
    query_x = 6'(x);
    query_y = 5'(y);
    #1;
    chk("query_body", int'(query_body), int'(eb));
    chk("query_head", int'(query_head), int'(eh));
  endtask

  bit   mon_en = 0;
  bit   pw = 0;
  bit   pb = 0;
  int   mk;
  exp_t me;

  always @(negedge clk) begin
    if (mon_en) begin
      mk = (move_tick ? K_MOVE : 0) | ((hit_wall && !pw) ? K_WALL : 0) | ((hit_body && !pb) ? K_BODY : 0);
      if (mk != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", mk, 0);
        end else begin
          me = exp_q.pop_front();
          chk("ev_kind", mk, me.kind);
          chk("ev_cycle", int'(ncyc), int'(me.cyc));
          chk("ev_head_x", int'(head_x), me.hx);
          chk("ev_head_y", int'(head_y), me.hy);
          chk("ev_len", int'(snake_len), me.len);
        end
      end
    end
    pw = hit_wall;
    pb = hit_body;
  end

  initial begin
    int st;
    logic [3:0] k;
    bit g, r;
    int idx;

    model_init();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1;

    idle(ST_START, 1);
    check_state("reset");
    chk("reset_move_tick", int'(move_tick), 0);
    idle(ST_START, 1); qchk(19, 15);
    idle(ST_START, 1); qchk(20, 15);
    idle(ST_START, 1); qchk(0, 0);

    // straight run, reverse request, coincident keys
    idle(ST_PLAY, 3 * DIV);
    period(4'b0010, 1'b0);
    period(4'b1001, 1'b0);
    period(4'b0000, 1'b0);
    idle(ST_START, 1);
    check_state("keys");

    // wall collision and recovery
    cyc(4'b0, ST_START, 1'b1, 1'b0);
    idle(ST_PLAY, 22 * DIV);
    check_state("wall");
    cyc(4'b0, ST_START, 1'b1, 1'b0);
    idle(ST_START, 1);
    check_state("restart");

    // growth then body collision
    cyc(4'b0, ST_START, 1'b1, 1'b0);
    repeat (3) period(4'b0000, 1'b1);
    period(4'b1000, 1'b0);
    period(4'b0010, 1'b0);
    period(4'b0100, 1'b0);
    idle(ST_START, 1);
    check_state("body_hit");

    // chase the vacating tail at len 4
    cyc(4'b0, ST_START, 1'b1, 1'b0);
    period(4'b0000, 1'b1);
    period(4'b1000, 1'b0);
    period(4'b0010, 1'b0);
    period(4'b0100, 1'b0);
    period(4'b0000, 1'b0);
    idle(ST_START, 1);
    check_state("tail");

    // saturate at MAX_LEN
    cyc(4'b0, ST_START, 1'b1, 1'b0);
    repeat (16) period(4'b0000, 1'b1);
    idle(ST_START, 1);
    check_state("max_len");

    // frozen in START, then first step timing
    cyc(4'b0, ST_START, 1'b1, 1'b0);
    idle(ST_START, 100);
    check_state("start_hold");
    idle(ST_START, 1); qchk(19, 15);
    idle(ST_START, 1); qchk(20, 15);
    idle(ST_START, 1); qchk(0, 0);
    idle(ST_PLAY, 2 * DIV);

    // randomized play
    for (int rnd = 0; rnd < 8; rnd++) begin
      cyc(4'b0, ST_START, 1'b1, 1'b0);
      st = ST_PLAY;
      for (int c = 0; c < 300; c++) begin
        if (c % 40 == 0) begin
          idx = int'($urandom_range(0, 9));
          st = (idx < 7) ? ST_PLAY : (idx == 7) ? ST_START : (idx == 8) ? ST_DIE : ST_RESTART;
        end
        k = 4'b0;
        if ($urandom_range(0, 5) == 0) k = 4'b0001 << $urandom_range(0, 3);
        g = ($urandom_range(0, 9) == 0);
        r = ($urandom_range(0, 299) == 0);
        cyc(k, st, r, g);
      end
      idle(ST_START, 1);
      check_state("rand");
      repeat (4) begin
        idle(ST_START, 1);
        idx = int'($urandom_range(0, sx.size() - 1));
        qchk(sx[idx], sy[idx]);
        idle(ST_START, 1);
        qchk(int'($urandom_range(0, GW - 1)), int'($urandom_range(0, GH - 1)));
      end
    end

    idle(ST_START, 3);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
